upscale_2x: RTL and testbench

- 2x nearest-neighbour upscaler for one 8-bit channel: 960x540 -> 1920x1080.
- Inverse of the 2x2 average-pooling downscale path. Sits between the frame-buffer read side and the HDMI output formatter.
- Each input pixel is emitted twice horizontally. Each input line is emitted twice vertically; the repeat line is replayed from an internal line buffer.
- Streaming valid/ready on both sides, one instance per colour channel.

---
 rtl/upscale_pkg.sv | 19 +
 rtl/upscale_linebuf.sv | 31 +++
 rtl/upscale_2x.sv | 172 +++++++++++++++++
 tb/tb_upscale_2x.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/upscale_pkg.sv
// upscale_2x shared definitions: FSM encodings, frame geometry defaults.
// The optional UPSCALE_HINTERP_EN build reuses these unchanged.
package upscale_pkg;

    localparam logic [1:0] WAIT_SOF = 2'd0;
    localparam logic [1:0] PASS_A   = 2'd1;
    localparam logic [1:0] PASS_B   = 2'd2;

    localparam int DEF_SRC_W = 960;
    localparam int DEF_SRC_H = 540;

    localparam int LAST_COL  = DEF_SRC_W - 1;
    localparam int LAST_LINE = DEF_SRC_H - 1;

    function automatic int last_of(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/upscale_linebuf.sv
// Simple dual-port line store: one write port, one registered read port.
// Holds the live line so the duplicate output line can be replayed.
module upscale_linebuf #(
    parameter int DEPTH = 960,
    parameter int DW    = 8,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/upscale_2x.sv
// 2x nearest-neighbour upscaler, one channel, valid/ready both sides.
// Define UPSCALE_HINTERP_EN for horizontal linear interpolation.
module upscale_2x
    import upscale_pkg::*;
#(
    parameter int SRC_W = DEF_SRC_W,
    parameter int SRC_H = DEF_SRC_H,
    parameter int DW    = 8,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_sof,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_sof,
    output logic          m_eol
);

    localparam logic [XW-1:0] C_LAST_X = XW'(last_of(SRC_W));
    localparam logic [YW-1:0] C_LAST_Y = YW'(last_of(SRC_H));

    logic [1:0]    r_st;
    logic          r_ph;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [DW-1:0] r_hold;
    logic          r_mv;
    logic [DW-1:0] r_md;
    logic          r_msof;
    logic          r_meol;

    logic          w_free;
    logic          w_rdy;
    logic          w_take;
    logic          w_a1;
    logic          w_b;
    logic          w_last;
    logic          w_re;
    logic          w_load;
    logic          w_osof;
    logic          w_oeol;
    logic [XW-1:0] w_col;
    logic [XW-1:0] w_raddr;
    logic [DW-1:0] w_rd;
    logic [DW-1:0] w_pix;
    logic [DW-1:0] w_first;
    logic [DW-1:0] w_od;

    always_comb begin
        w_free = !r_mv || m_ready;
        w_rdy  = 1'b0;
        unique case (r_st)
            WAIT_SOF: w_rdy = w_free;
            PASS_A:   w_rdy = !r_ph && w_free;
            default:  w_rdy = 1'b0;
        endcase
    end

    assign s_ready = w_rdy && !rst;
    assign w_take  = s_valid && s_ready && (s_sof || r_st == PASS_A);
    assign w_col   = s_sof ? '0 : r_x;
    assign w_last  = (r_x == C_LAST_X);
    assign w_a1    = (r_st == PASS_A) && r_ph && w_free;
    assign w_b     = (r_st == PASS_B) && w_free;
    assign w_load  = w_take || w_a1 || w_b;

    // Replay prefetch: next column is read while the current one repeats.
    assign w_re    = (w_a1 && w_last) || (w_b && !r_ph && !w_last);
    assign w_raddr = (r_st == PASS_B) ? r_x + 1'b1 : '0;

    assign w_pix = (r_st == PASS_B) ? w_rd : s_data;

`ifdef UPSCALE_HINTERP_EN
    logic w_x0;
    assign w_x0    = (r_st == PASS_B) ? (r_x == '0) : (w_col == '0);
    // r_hold still carries the previous column's pixel at phase 0.
    assign w_first = w_x0 ? w_pix
                   : DW'(({1'b0, r_hold} + {1'b0, w_pix}) >> 1);
`else
    assign w_first = w_pix;
`endif

    assign w_od   = r_ph ? r_hold : w_first;
    assign w_osof = w_take && s_sof;
    assign w_oeol = r_ph && w_last;

    upscale_linebuf #(
        .DEPTH (SRC_W),
        .DW    (DW),
        .AW    (XW)
    ) u_linebuf (
        .clk     (clk),
        .i_we    (w_take),
        .i_waddr (w_col),
        .i_wdata (s_data),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st   <= WAIT_SOF;
            r_ph   <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_hold <= '0;
            r_mv   <= 1'b0;
            r_md   <= '0;
            r_msof <= 1'b0;
            r_meol <= 1'b0;
        end else begin
            if (w_load) begin
                r_mv   <= 1'b1;
                r_md   <= w_od;
                r_msof <= w_osof;
                r_meol <= w_oeol;
            end else if (m_ready) begin
                r_mv   <= 1'b0;
            end

            if (w_take) begin
                r_st   <= PASS_A;
                r_ph   <= 1'b1;
                r_x    <= w_col;
                r_hold <= s_data;
                if (s_sof) begin
                    r_y <= '0;
                end
            end else if (w_a1) begin
                r_ph <= 1'b0;
                if (w_last) begin
                    r_x  <= '0;
                    r_st <= PASS_B;
                end else begin
                    r_x  <= r_x + 1'b1;
                end
            end else if (w_b) begin
                if (!r_ph) begin
                    r_ph   <= 1'b1;
                    r_hold <= w_rd;
                end else begin
                    r_ph <= 1'b0;
                    if (w_last) begin
                        r_x <= '0;
                        if (r_y == C_LAST_Y) begin
                            r_y  <= '0;
                            r_st <= WAIT_SOF;
                        end else begin
                            r_y  <= r_y + 1'b1;
                            r_st <= PASS_A;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
            end
        end
    end

    assign m_valid = r_mv;
    assign m_data  = r_md;
    assign m_sof   = r_msof;
    assign m_eol   = r_meol;

endmodule

// File: tb/tb_upscale_2x.sv
// Directed bench for upscale_2x on a 4x2 source frame.
// Expected beats follow UPSCALE_HINTERP_EN when it is defined.
module tb_upscale_2x;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_sof;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_eol;

    int checks;
    int errors;

    logic [7:0] in_data  [64];
    logic       in_sof   [64];
    int         n_in;
    logic [7:0] exp_data [128];
    logic       exp_sof  [128];
    logic       exp_eol  [128];
    int         n_exp;

    upscale_2x #(
        .SRC_W (4),
        .SRC_H (2),
        .DW    (8),
        .XW    (3),
        .YW    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sof   (s_sof),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic add_in(input int d, input bit s);
        in_data[n_in] = d[7:0];
        in_sof[n_in]  = s;
        n_in++;
    endtask

    task automatic add_exp(input int d, input bit s, input bit e);
        exp_data[n_exp] = d[7:0];
        exp_sof[n_exp]  = s;
        exp_eol[n_exp]  = e;
        n_exp++;
    endtask

    // Expected output beats for the first n columns of one output line.
    task automatic exp_seg(input int p0, input int p1, input int p2,
                           input int p3, input int n, input bit sof0);
        int p [4];
        int prev;
        int b0;
        p = '{p0, p1, p2, p3};
        prev = 0;
        for (int x = 0; x < n; x++) begin
`ifdef UPSCALE_HINTERP_EN
            b0 = (x == 0) ? p[x] : (prev + p[x]) / 2;
`else
            b0 = p[x];
`endif
            add_exp(b0, sof0 && x == 0, 1'b0);
            add_exp(p[x], 1'b0, x == 3);
            prev = p[x];
        end
    endtask

    task automatic make_frame(input int a0, input int a1, input int a2,
                              input int a3, input int b0, input int b1,
                              input int b2, input int b3);
        n_in  = 0;
        n_exp = 0;
        add_in(a0, 1'b1);
        add_in(a1, 1'b0);
        add_in(a2, 1'b0);
        add_in(a3, 1'b0);
        add_in(b0, 1'b0);
        add_in(b1, 1'b0);
        add_in(b2, 1'b0);
        add_in(b3, 1'b0);
        exp_seg(a0, a1, a2, a3, 4, 1'b1);
        exp_seg(a0, a1, a2, a3, 4, 1'b0);
        exp_seg(b0, b1, b2, b3, 4, 1'b0);
        exp_seg(b0, b1, b2, b3, 4, 1'b0);
    endtask

    // Streams in_data, collects stop_at beats and checks each against exp.
    task automatic run(input int mode, input int stop_at, input bit chk_b);
        int ii;
        int oi;
        int cyc;
        logic pv;
        logic [7:0] pd;
        logic ps;
        logic pe;
        ii  = 0;
        oi  = 0;
        cyc = 0;
        pv  = 1'b0;
        pd  = '0;
        ps  = 1'b0;
        pe  = 1'b0;
        while (oi < stop_at && cyc < 1000) begin
            @(negedge clk);
            m_ready = (mode == 0) ? 1'b1 : (cyc % 4 == 0 || cyc % 4 == 3);
            s_valid = (ii < n_in);
            s_data  = (ii < n_in) ? in_data[ii] : 8'd0;
            s_sof   = (ii < n_in) ? in_sof[ii] : 1'b0;
            #1;
            if (pv) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, pd);
                chk("stall_sof", m_sof, ps);
                chk("stall_eol", m_eol, pe);
            end
            if (chk_b && m_valid === 1'b1 && oi % 16 >= 7 && oi % 16 <= 14)
                chk("sready_passb", s_ready, 0);
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                if (oi < n_exp) begin
                    chk($sformatf("beat%0d_data", oi), m_data, exp_data[oi]);
                    chk($sformatf("beat%0d_sof", oi), m_sof, exp_sof[oi]);
                    chk($sformatf("beat%0d_eol", oi), m_eol, exp_eol[oi]);
                end else begin
                    chk("extra_beat", m_valid, 0);
                end
                oi++;
            end
            pv = (m_valid === 1'b1) && (m_ready === 1'b0);
            pd = m_data;
            ps = m_sof;
            pe = m_eol;
            if (s_valid === 1'b1 && s_ready === 1'b1)
                ii++;
            cyc++;
        end
        chk("beat_count", oi, stop_at);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic drop(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_sof   = 1'b0;
            s_data  = 8'(k + 1);
            m_ready = 1'b1;
            #1;
            chk("drop_ready", s_ready, 1);
            chk("drop_mvalid", m_valid, 0);
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("drop_mvalid_end", m_valid, 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        n_in    = 0;
        n_exp   = 0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_sof   = 1'b0;
        m_ready = 1'b1;

        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_mvalid", m_valid, 0);
            chk("rst_sready", s_ready, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_mvalid", m_valid, 0);
        chk("post_rst_mdata", m_data, 0);
        chk("post_rst_msof", m_sof, 0);
        chk("post_rst_meol", m_eol, 0);

        drop(4);

        make_frame(10, 20, 30, 40, 50, 60, 70, 80);
        run(0, 32, 1'b1);

        make_frame(10, 20, 30, 40, 50, 60, 70, 80);
        run(1, 32, 1'b1);

        make_frame(255, 254, 0, 1, 1, 2, 3, 4);
        run(0, 32, 1'b1);

        n_in  = 0;
        n_exp = 0;
        add_in(10, 1'b1);
        add_in(20, 1'b0);
        add_in(99, 1'b1);
        add_in(100, 1'b0);
        add_in(110, 1'b0);
        add_in(120, 1'b0);
        add_in(5, 1'b0);
        add_in(6, 1'b0);
        add_in(7, 1'b0);
        add_in(8, 1'b0);
        exp_seg(10, 20, 30, 40, 2, 1'b1);
        exp_seg(99, 100, 110, 120, 4, 1'b1);
        exp_seg(99, 100, 110, 120, 4, 1'b0);
        exp_seg(5, 6, 7, 8, 4, 1'b0);
        exp_seg(5, 6, 7, 8, 4, 1'b0);
        run(0, 36, 1'b0);

        make_frame(10, 20, 30, 40, 50, 60, 70, 80);
        run(0, 10, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_mvalid", m_valid, 0);
        chk("midrst_sready", s_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        drop(3);
        make_frame(11, 22, 33, 44, 55, 66, 77, 88);
        run(1, 32, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
